// File: rtl/mem_access_unit_if.sv
// Bundle between the MEM-stage pipeline, the load/store unit and DataMemory.
// The unit uses the slave view; the pipeline/memory environment uses master.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        Mem_read;
  logic        Mem_write;
  logic [31:0] Mem_address;
  logic [31:0] Write_data;
  logic [31:0] Read_Data;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, Read_Data,
    input  req_ready, resp_valid, resp_rdata, resp_error,
           Mem_read, Mem_write, Mem_address, Write_data
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, Read_Data,
    output req_ready, resp_valid, resp_rdata, resp_error,
           Mem_read, Mem_write, Mem_address, Write_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit driving DataMemory; sub-word stores use read-modify-write.
// Optional macro MAU_MISALIGN_TRAP_EN: misaligned half/word accesses respond with an error.
//
// state   | meaning
// IDLE    | ready for a request
// READ    | Mem_read held for MEM_LATENCY cycles
// WRITE   | Mem_write for one cycle
// RESP    | resp_valid pulse
module mem_access_unit #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  mem_access_unit_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          write_q, write_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [1:0]    lo_q, lo_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic [31:0]   mem_address_q, mem_address_d;
  logic [31:0]   write_data_q, write_data_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_error_q, resp_error_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          misaligned;

`ifdef MAU_MISALIGN_TRAP_EN
  assign misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                      (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] sz,
                                               input logic uns, input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   load_extract = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   load_extract = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: load_extract = w;
    endcase
  endfunction

  // Only sub-word stores reach the merge; other bytes come from the read word.
  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [15:0] wd,
                                              input logic [1:0] sz, input logic [1:0] lo);
    logic [31:0] m;
    m = w;
    if (sz == 2'b00) begin
      case (lo)
        2'd0:    m[7:0]   = wd[7:0];
        2'd1:    m[15:8]  = wd[7:0];
        2'd2:    m[23:16] = wd[7:0];
        default: m[31:24] = wd[7:0];
      endcase
    end else if (lo[1]) begin
      m[31:16] = wd;
    end else begin
      m[15:0] = wd;
    end
    store_merge = m;
  endfunction

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    write_d       = write_q;
    size_d        = size_q;
    uns_d         = uns_q;
    lo_d          = lo_q;
    wdata_d       = wdata_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    write_data_d  = write_data_q;
    resp_valid_d  = resp_valid_q;
    resp_error_d  = resp_error_q;
    resp_rdata_d  = resp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          write_d       = bus.req_write;
          size_d        = bus.req_size;
          uns_d         = bus.req_unsigned;
          lo_d          = bus.req_addr[1:0];
          wdata_d       = bus.req_wdata[15:0];
          mem_address_d = {bus.req_addr[31:2], 2'b00};
          if (misaligned) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            resp_rdata_d = 32'h0;
          end else if (bus.req_write && bus.req_size[1]) begin
            state_d      = S_WRITE;
            mem_write_d  = 1'b1;
            write_data_d = bus.req_wdata;
          end else begin
            state_d    = S_READ;
            mem_read_d = 1'b1;
            cnt_d      = CW'(MEM_LATENCY - 1);
          end
        end
      end
      S_READ: begin
        if (cnt_q == '0) begin
          mem_read_d = 1'b0;
          if (write_q) begin
            state_d      = S_WRITE;
            mem_write_d  = 1'b1;
            write_data_d = store_merge(bus.Read_Data, wdata_q, size_q, lo_q);
          end else begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b0;
            resp_rdata_d = load_extract(bus.Read_Data, size_q, uns_q, lo_q);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WRITE: begin
        mem_write_d  = 1'b0;
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_error_d = 1'b0;
        resp_rdata_d = 32'h0;
      end
      default: begin
        resp_valid_d = 1'b0;
        state_d      = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      write_q       <= 1'b0;
      size_q        <= 2'b00;
      uns_q         <= 1'b0;
      lo_q          <= 2'b00;
      wdata_q       <= 16'h0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= 32'h0;
      write_data_q  <= 32'h0;
      resp_valid_q  <= 1'b0;
      resp_error_q  <= 1'b0;
      resp_rdata_q  <= 32'h0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      write_q       <= write_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      lo_q          <= lo_d;
      wdata_q       <= wdata_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      write_data_q  <= write_data_d;
      resp_valid_q  <= resp_valid_d;
      resp_error_q  <= resp_error_d;
      resp_rdata_q  <= resp_rdata_d;
    end
  end

  assign bus.req_ready   = (state_q == S_IDLE);
  assign bus.Mem_read    = mem_read_q;
  assign bus.Mem_write   = mem_write_q;
  assign bus.Mem_address = mem_address_q;
  assign bus.Write_data  = write_data_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_error  = resp_error_q;
  assign bus.resp_rdata  = resp_rdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one instance with MEM_LATENCY=1, one with 3,
// each attached to a small word memory.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;

  mem_access_unit_if ia ();
  mem_access_unit_if ib ();

  mem_access_unit #(.MEM_LATENCY(1)) dut_a (.clk(clk), .reset(reset), .bus(ia));
  mem_access_unit #(.MEM_LATENCY(3)) dut_b (.clk(clk), .reset(reset), .bus(ib));

  always #5 clk = ~clk;

  logic [31:0] mem_a [0:15];
  logic [31:0] mem_b [0:15];
  assign ia.Read_Data = mem_a[ia.Mem_address[5:2]];
  assign ib.Read_Data = mem_b[ib.Mem_address[5:2]];
  always @(posedge clk) begin
    if (ia.Mem_write) mem_a[ia.Mem_address[5:2]] <= ia.Write_data;
    if (ib.Mem_write) mem_b[ib.Mem_address[5:2]] <= ib.Write_data;
  end

  int          t_resp, t_rd_first, t_rd_cnt, t_wr_cyc, t_wr_cnt, t_both;
  logic [31:0] t_rdata, t_wdata;
  logic        t_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit v, input bit wr, input logic [1:0] sz,
                       input bit uns, input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      ib.req_valid = v; ib.req_write = wr; ib.req_size = sz;
      ib.req_unsigned = uns; ib.req_addr = a; ib.req_wdata = d;
    end else begin
      ia.req_valid = v; ia.req_write = wr; ia.req_size = sz;
      ia.req_unsigned = uns; ia.req_addr = a; ia.req_wdata = d;
    end
  endtask

  // Issues one request and traces the cycles after the accept edge (cycle 0).
  task automatic run(input bit sel, input bit wr, input logic [1:0] sz, input bit uns,
                     input logic [31:0] a, input logic [31:0] d);
    bit acc = 0;
    bit rd, wt, rv;
    t_resp = 0; t_rd_first = 0; t_rd_cnt = 0; t_wr_cyc = 0; t_wr_cnt = 0; t_both = 0;
    t_rdata = 32'hx; t_wdata = 32'hx; t_err = 1'bx;
    @(negedge clk);
    drive(sel, 1'b1, wr, sz, uns, a, d);
    for (int i = 0; i < 20 && !acc; i++) begin
      if (sel ? ib.req_ready : ia.req_ready) acc = 1;
      @(posedge clk);
      if (!acc) @(negedge clk);
    end
    #1 drive(sel, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    if (!acc) return;
    for (int c = 1; c <= 16 && t_resp == 0; c++) begin
      @(negedge clk);
      rd = sel ? ib.Mem_read : ia.Mem_read;
      wt = sel ? ib.Mem_write : ia.Mem_write;
      rv = sel ? ib.resp_valid : ia.resp_valid;
      if (rd) begin t_rd_cnt++; if (t_rd_first == 0) t_rd_first = c; end
      if (wt) begin t_wr_cnt++; t_wr_cyc = c; t_wdata = sel ? ib.Write_data : ia.Write_data; end
      if (rd && wt) t_both = 1;
      if (rv) begin
        t_resp  = c;
        t_rdata = sel ? ib.resp_rdata : ia.resp_rdata;
        t_err   = sel ? ib.resp_error : ia.resp_error;
      end
    end
  endtask

  initial begin
    int r1, r2, acc2, rdn;
    logic [31:0] r1_data;
    drive(0, 0, 0, 2'b00, 0, 32'h0, 32'h0);
    drive(1, 0, 0, 2'b00, 0, 32'h0, 32'h0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_read", {31'b0, ia.Mem_read}, 32'h0);
    chk("rst_mem_write", {31'b0, ia.Mem_write}, 32'h0);
    chk("rst_resp_valid", {31'b0, ia.resp_valid}, 32'h0);
    chk("rst_resp_error", {31'b0, ia.resp_error}, 32'h0);
    chk("rst_mem_address", ia.Mem_address, 32'h0);
    chk("rst_write_data", ia.Write_data, 32'h0);
    chk("rst_resp_rdata", ia.resp_rdata, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready_after", {31'b0, ia.req_ready}, 32'h1);

    // word store then word load
    run(0, 1, 2'b10, 0, 32'h0, 32'h00000014);
    chk("t1_st_wr_cyc", t_wr_cyc, 1);
    chk("t1_st_wr_cnt", t_wr_cnt, 1);
    chk("t1_st_rd_cnt", t_rd_cnt, 0);
    chk("t1_st_resp", t_resp, 2);
    chk("t1_st_rdata", t_rdata, 32'h0);
    run(0, 0, 2'b10, 0, 32'h0, 32'h0);
    chk("t1_ld_rd_first", t_rd_first, 1);
    chk("t1_ld_rd_cnt", t_rd_cnt, 1);
    chk("t1_ld_wr_cnt", t_wr_cnt, 0);
    chk("t1_ld_resp", t_resp, 2);
    chk("t1_ld_rdata", t_rdata, 32'h00000014);

    // byte store read-modify-write and byte loads
    run(0, 1, 2'b11, 0, 32'h4, 32'h11223344);
    chk("t2_st_word_wdata", t_wdata, 32'h11223344);
    run(0, 1, 2'b00, 0, 32'h6, 32'hFFFFFF80);
    chk("t2_bst_rd_first", t_rd_first, 1);
    chk("t2_bst_wr_cyc", t_wr_cyc, 2);
    chk("t2_bst_resp", t_resp, 3);
    chk("t2_bst_wdata", t_wdata, 32'h11803344);
    chk("t2_bst_both", t_both, 0);
    chk("t2_mem_word", mem_a[1], 32'h11803344);
    run(0, 0, 2'b00, 0, 32'h6, 32'h0);
    chk("t2_lb_signed", t_rdata, 32'hFFFFFF80);
    run(0, 0, 2'b00, 1, 32'h6, 32'h0);
    chk("t2_lb_unsigned", t_rdata, 32'h00000080);
    run(0, 0, 2'b00, 1, 32'h7, 32'h0);
    chk("t2_lb_lane3", t_rdata, 32'h00000011);

    // half loads
    run(0, 1, 2'b10, 0, 32'h8, 32'hABCD1234);
    run(0, 0, 2'b01, 0, 32'hA, 32'h0);
    chk("t3_lh_signed", t_rdata, 32'hFFFFABCD);
    run(0, 0, 2'b01, 1, 32'h8, 32'h0);
    chk("t3_lh_unsigned", t_rdata, 32'h00001234);
    run(0, 1, 2'b01, 0, 32'h8, 32'h00005A5A);
    chk("t3_sh_wdata", t_wdata, 32'hABCD5A5A);

    // misaligned word load
    run(0, 0, 2'b10, 0, 32'h2, 32'h0);
`ifdef MAU_MISALIGN_TRAP_EN
    chk("t4_resp", t_resp, 1);
    chk("t4_err", {31'b0, t_err}, 32'h1);
    chk("t4_rd_cnt", t_rd_cnt, 0);
    chk("t4_rdata", t_rdata, 32'h0);
`else
    chk("t4_resp", t_resp, 2);
    chk("t4_err", {31'b0, t_err}, 32'h0);
    chk("t4_rd_cnt", t_rd_cnt, 1);
    chk("t4_rdata", t_rdata, 32'h00000014);
`endif

    // reset in the middle of a byte store
    run(0, 1, 2'b10, 0, 32'hC, 32'h55667788);
    @(negedge clk);
    drive(0, 1, 1, 2'b00, 0, 32'hD, 32'h00000099);
    @(posedge clk);
    #1 drive(0, 0, 0, 2'b00, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t5_read_before", {31'b0, ia.Mem_read}, 32'h1);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_read_after", {31'b0, ia.Mem_read}, 32'h0);
    chk("t5_write_after", {31'b0, ia.Mem_write}, 32'h0);
    chk("t5_resp_after", {31'b0, ia.resp_valid}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_ready_release", {31'b0, ia.req_ready}, 32'h1);
    chk("t5_mem_unchanged", mem_a[3], 32'h55667788);
    run(0, 0, 2'b10, 0, 32'hC, 32'h0);
    chk("t5_reload", t_rdata, 32'h55667788);

    // latency 3, request held across a busy load
    run(1, 1, 2'b10, 0, 32'h0, 32'hCAFEF00D);
    chk("t6_st_resp", t_resp, 2);
    @(negedge clk);
    drive(1, 1, 0, 2'b10, 0, 32'h0, 32'h0);
    r1 = 0; r2 = 0; acc2 = 0; rdn = 0; r1_data = 32'h0;
    @(posedge clk);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (ib.Mem_read) rdn++;
      if (ib.resp_valid) begin
        if (r1 == 0) begin r1 = c; r1_data = ib.resp_rdata; end
        else if (r2 == 0) r2 = c;
      end
      if (ib.req_ready && ib.req_valid && acc2 == 0) begin
        acc2 = c;
        @(posedge clk);
        #1 drive(1, 0, 0, 2'b00, 0, 32'h0, 32'h0);
      end
    end
    chk("t6_resp1_cyc", r1, 4);
    chk("t6_resp1_data", r1_data, 32'hCAFEF00D);
    chk("t6_accept2_cyc", acc2, 5);
    chk("t6_resp2_cyc", r2, 9);
    chk("t6_read_cycles", rdn, 6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
